counter_scheduler: RTL

COUNTER_SCHEDULER -- requirements
Module: counter_scheduler

---
 rtl/counter_pkg.sv | 18 +
 rtl/counter_scheduler_if.sv | 32 +++
 rtl/rr_arbiter2.sv | 14 +
 rtl/counter_scheduler.sv | 130 +++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared FSM encoding and defaults for the counter scheduler slice.
// Pure declarations: no logic, no latency, no flow control.
package counter_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'b00;
    localparam state_t ST_ISSUE = 2'b01;
    localparam state_t ST_CLEAR = 2'b10;

    localparam int TICK_DIV_DEFAULT = 4;

    // Phase counter needs at least one bit even when the prescaler is 1.
    function automatic int phase_width(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/counter_scheduler_if.sv
// Requester/counter-side signal bundle of the scheduler; master drives requests, slave is the scheduler.
// Wires only: no latency; Req is held until the one-cycle Ack.
interface counter_scheduler_if #(
    parameter int CNT_W = 8
);

    logic             Req0;
    logic             Req1;
    logic             Slt0;
    logic             Slt1;
    logic             Clear;
    logic             Ack0;
    logic             Ack1;
    logic             Cnt_En;
    logic             Cnt_Slt;
    logic             Cnt_Reset;
    logic             Tick1;
    logic             Grant_Id;
    logic [CNT_W-1:0] Tally0;
    logic [CNT_W-1:0] Tally1;

    modport master (
        output Req0, Req1, Slt0, Slt1, Clear,
        input  Ack0, Ack1, Cnt_En, Cnt_Slt, Cnt_Reset, Tick1, Grant_Id, Tally0, Tally1
    );

    modport slave (
        input  Req0, Req1, Slt0, Slt1, Clear,
        output Ack0, Ack1, Cnt_En, Cnt_Slt, Cnt_Reset, Tick1, Grant_Id, Tally0, Tally1
    );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick: when both are eligible, the one not granted last wins.
// Combinational, zero latency; no backpressure (caller masks eligibility).
module rr_arbiter2 (
    input  logic elig0,
    input  logic elig1,
    input  logic last_ptr,
    output logic grant_vld,
    output logic winner
);

    assign grant_vld = elig0 | elig1;
    assign winner    = (elig0 & elig1) ? ~last_ptr : elig1;

endmodule

// File: rtl/counter_scheduler.sv
// Arbitrates two increment requesters onto a two-channel Counter, with clear, tallies and ch1 prescale tick.
// Req-to-Ack latency 1 cycle, all outputs registered; Req held until Ack, re-eligible the cycle after Ack.
module counter_scheduler
    import counter_pkg::*;
#(
    parameter int CNT_W    = 8,
    parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
    input  logic                Clk,
    input  logic                Reset,
    counter_scheduler_if.slave  bus
);

    localparam int               PH_W      = phase_width(TICK_DIV);
    localparam logic [PH_W-1:0]  PH_LAST   = PH_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] TALLY_MAX = '1;

    state_t           state;
    state_t           state_nxt;
    logic             armed;
    logic             last_ptr;
    logic [PH_W-1:0]  phase;
    logic [CNT_W-1:0] tally0;
    logic [CNT_W-1:0] tally1;

    logic             ack0;
    logic             ack1;
    logic             cnt_en;
    logic             cnt_slt;
    logic             cnt_reset;
    logic             tick1;
    logic             grant_id;

    logic             elig0;
    logic             elig1;
    logic             grant_vld;
    logic             winner;
    logic             issue;
    logic             win_slt;
    logic             phase_wrap;

    // A Req still high during its own Ack cycle is the tail of the served request.
    assign elig0 = bus.Req0 & ~ack0;
    assign elig1 = bus.Req1 & ~ack1;

    rr_arbiter2 u_arb (
        .elig0     (elig0),
        .elig1     (elig1),
        .last_ptr  (last_ptr),
        .grant_vld (grant_vld),
        .winner    (winner)
    );

    // 'armed' holds off any decision on the first edge after reset release.
    always_comb begin
        state_nxt = ST_IDLE;
        if (!armed) begin
            state_nxt = ST_IDLE;
        end else if (state == ST_CLEAR) begin
            state_nxt = ST_IDLE;
        end else if (bus.Clear) begin
            state_nxt = ST_CLEAR;
        end else if (grant_vld) begin
            state_nxt = ST_ISSUE;
        end
    end

    assign issue      = (state_nxt == ST_ISSUE);
    assign win_slt    = winner ? bus.Slt1 : bus.Slt0;
    assign phase_wrap = (phase == PH_LAST);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state     <= ST_IDLE;
            armed     <= 1'b0;
            last_ptr  <= 1'b1;
            phase     <= '0;
            tally0    <= '0;
            tally1    <= '0;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            cnt_en    <= 1'b0;
            cnt_slt   <= 1'b0;
            cnt_reset <= 1'b1;
            tick1     <= 1'b0;
            grant_id  <= 1'b0;
        end else begin
            armed     <= 1'b1;
            state     <= state_nxt;
            ack0      <= issue & ~winner;
            ack1      <= issue & winner;
            cnt_en    <= issue;
            cnt_reset <= (state_nxt == ST_CLEAR);
            tick1     <= issue & win_slt & phase_wrap;

            if (issue) begin
                cnt_slt  <= win_slt;
                grant_id <= winner;
                last_ptr <= winner;
            end

            if (state_nxt == ST_CLEAR) begin
                tally0 <= '0;
                tally1 <= '0;
                phase  <= '0;
            end else if (issue) begin
                if (!winner && (tally0 != TALLY_MAX)) begin
                    tally0 <= tally0 + 1'b1;
                end
                if (winner && (tally1 != TALLY_MAX)) begin
                    tally1 <= tally1 + 1'b1;
                end
                if (win_slt) begin
                    phase <= phase_wrap ? '0 : phase + 1'b1;
                end
            end
        end
    end

    assign bus.Ack0      = ack0;
    assign bus.Ack1      = ack1;
    assign bus.Cnt_En    = cnt_en;
    assign bus.Cnt_Slt   = cnt_slt;
    assign bus.Cnt_Reset = cnt_reset;
    assign bus.Tick1     = tick1;
    assign bus.Grant_Id  = grant_id;
    assign bus.Tally0    = tally0;
    assign bus.Tally1    = tally1;

endmodule
